// File: rtl/register_file_mp.sv
// Multi-port register file with two prioritised write ports, same-cycle bypass,
// hardwired-zero register 0 and a per-register pending scoreboard.
module register_file_mp #(
  parameter int DATA_W = 16,
  parameter int N_REG  = 32,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(N_REG)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic [1:0]               we,
  input  logic [2*ADDR_W-1:0]      waddr,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [N_REG-1:0]         pending
);

  logic [DATA_W-1:0] r_regs [N_REG];
  logic [N_REG-1:0]  r_pending;

  logic [1:0]        w_we;
  logic [ADDR_W-1:0] w_waddr [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic              w_issue;

  // Writes and issues are suppressed while reset is held, including the bypass path.
  assign w_we       = we & {2{arst_n}};
  assign w_issue    = issue_en & arst_n;
  assign w_waddr[0] = waddr[0 +: ADDR_W];
  assign w_waddr[1] = waddr[ADDR_W +: ADDR_W];
  assign w_wdata[0] = wdata[0 +: DATA_W];
  assign w_wdata[1] = wdata[DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int a = 0; a < N_REG; a++) begin
        r_regs[a] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int a = 1; a < N_REG; a++) begin
        if (w_we[1] && w_waddr[1] == ADDR_W'(a)) begin
          r_regs[a] <= w_wdata[1];
        end else if (w_we[0] && w_waddr[0] == ADDR_W'(a)) begin
          r_regs[a] <= w_wdata[0];
        end
        // A newly issued producer supersedes the write landing in the same cycle.
        if (w_issue && issue_addr == ADDR_W'(a)) begin
          r_pending[a] <= 1'b1;
        end else if ((w_we[0] && w_waddr[0] == ADDR_W'(a)) ||
                     (w_we[1] && w_waddr[1] == ADDR_W'(a))) begin
          r_pending[a] <= 1'b0;
        end
      end
    end
  end

  assign pending = r_pending;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_zero;
      logic              w_hit0;
      logic              w_hit1;

      assign w_ra   = raddr[k*ADDR_W +: ADDR_W];
      assign w_zero = (w_ra == '0);
      assign w_hit0 = w_we[0] && (w_waddr[0] == w_ra);
      assign w_hit1 = w_we[1] && (w_waddr[1] == w_ra);

      assign rdata[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                         w_hit1 ? w_wdata[1] :
                                         w_hit0 ? w_wdata[0] :
                                         r_regs[w_ra];
      assign rvalid[k] = w_zero || w_hit0 || w_hit1 || !r_pending[w_ra];
    end
  endgenerate

endmodule
